cpx_mac: RTL and testbench

Pipelined complex multiply-accumulate for the CAF correlation path. Each accepted sample pair forms x·y or x·conj(y). Products are summed over a frame delimited by `in_last`. The frame sum is rounded, shifted and saturated, then emitted as one `out_valid` pulse. The block feeds the CAF peak search, and frames may run back-to-back with no bubble.

---
 rtl/caf_cpx_pkg.sv | 21 ++
 rtl/cpx_mac_if.sv | 29 ++
 rtl/cpx_round_sat.sv | 39 +++
 rtl/cpx_mac.sv | 154 +++++++++++++++
 tb/tb_cpx_mac.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/caf_cpx_pkg.sv
// Shared types and helpers for the CAF complex-arithmetic path.
// Provides product-width sizing, signed range limits and conjugate-mode codes.
package caf_cpx_pkg;

    localparam logic CPX_MUL  = 1'b0;
    localparam logic CPX_CONJ = 1'b1;

    // Width of a combined complex product term (sum/difference of two products).
    function automatic int prod_bits(input int a, input int b);
        return a + b + 1;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/cpx_mac_if.sv
// Sample-in / frame-result-out bundle for cpx_mac.
// master drives samples and consumes results; slave is the MAC itself.
interface cpx_mac_if #(
    parameter int x_bits   = 12,
    parameter int y_bits   = 12,
    parameter int out_bits = 24
);
    logic                       in_valid;
    logic                       in_last;
    logic                       conj_y;
    logic signed [x_bits-1:0]   xi;
    logic signed [x_bits-1:0]   xq;
    logic signed [y_bits-1:0]   yi;
    logic signed [y_bits-1:0]   yq;
    logic                       out_valid;
    logic signed [out_bits-1:0] out_i;
    logic signed [out_bits-1:0] out_q;
    logic                       out_ovf;

    modport master (
        output in_valid, in_last, conj_y, xi, xq, yi, yq,
        input  out_valid, out_i, out_q, out_ovf
    );

    modport slave (
        input  in_valid, in_last, conj_y, xi, xq, yi, yq,
        output out_valid, out_i, out_q, out_ovf
    );
endinterface

// File: rtl/cpx_round_sat.sv
// One-component output conditioner: round half toward +inf, arithmetic shift,
// then clamp to the signed out_bits range, flagging any clamp.
module cpx_round_sat
    import caf_cpx_pkg::*;
#(
    parameter int acc_bits  = 40,
    parameter int out_bits  = 24,
    parameter int out_shift = 0
) (
    input  logic signed [acc_bits-1:0] i_acc,
    output logic signed [out_bits-1:0] o_val,
    output logic                       o_sat
);
    localparam int W = acc_bits + 1;
    localparam logic signed [W-1:0] W_MAX = W'(sat_max(out_bits));
    localparam logic signed [W-1:0] W_MIN = W'(sat_min(out_bits));
    // Half an LSB of the shifted result; collapses to zero when no shift is applied.
    localparam logic signed [W-1:0] W_RND = (W'(1) << out_shift) >> 1;

    logic signed [W-1:0] w_ext;
    logic signed [W-1:0] w_rnd;
    logic signed [W-1:0] w_shf;

    always_comb begin
        w_ext = W'(i_acc);
        w_rnd = w_ext + W_RND;
        w_shf = w_rnd >>> out_shift;
        o_sat = 1'b0;
        o_val = w_shf[out_bits-1:0];
        if (w_shf > W_MAX) begin
            o_val = W_MAX[out_bits-1:0];
            o_sat = 1'b1;
        end else if (w_shf < W_MIN) begin
            o_val = W_MIN[out_bits-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/cpx_mac.sv
// Four-stage pipelined complex multiply-accumulate over in_last-delimited frames,
// emitting one rounded, shifted, saturated result per frame.
module cpx_mac
    import caf_cpx_pkg::*;
#(
    parameter int x_bits    = 12,
    parameter int y_bits    = 12,
    parameter int acc_bits  = 40,
    parameter int out_bits  = 24,
    parameter int out_shift = 0
) (
    input  logic      clk,
    input  logic      rst,
    cpx_mac_if.slave  bus
);
    localparam int PW = x_bits + y_bits;
    localparam int SW = prod_bits(x_bits, y_bits);
    localparam logic signed [acc_bits-1:0] ACC_MAX = acc_bits'(sat_max(acc_bits));
    localparam logic signed [acc_bits-1:0] ACC_MIN = acc_bits'(sat_min(acc_bits));

    if (acc_bits < prod_bits(x_bits, y_bits)) begin : g_chk_acc
        $error("cpx_mac: acc_bits must be >= x_bits+y_bits+1");
    end
    if (out_bits > acc_bits) begin : g_chk_out
        $error("cpx_mac: out_bits must be <= acc_bits");
    end
    if (out_shift < 0 || out_shift > acc_bits - 1) begin : g_chk_shift
        $error("cpx_mac: out_shift must be in 0..acc_bits-1");
    end

    logic                 r_s1_valid, r_s1_last, r_s1_conj;
    logic signed [PW-1:0] r_s1_ii, r_s1_qq, r_s1_iq, r_s1_qi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_conj  <= 1'b0;
            r_s1_ii    <= '0;
            r_s1_qq    <= '0;
            r_s1_iq    <= '0;
            r_s1_qi    <= '0;
        end else begin
            r_s1_valid <= bus.in_valid;
            r_s1_last  <= bus.in_valid & bus.in_last;
            r_s1_conj  <= bus.conj_y;
            r_s1_ii    <= PW'(bus.xi) * PW'(bus.yi);
            r_s1_qq    <= PW'(bus.xq) * PW'(bus.yq);
            r_s1_iq    <= PW'(bus.xi) * PW'(bus.yq);
            r_s1_qi    <= PW'(bus.xq) * PW'(bus.yi);
        end
    end

    // Index 0 is the in-phase component, index 1 the quadrature component.
    logic                 r_s2_valid, r_s2_last;
    logic signed [SW-1:0] r_s2_p [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_p[0]  <= '0;
            r_s2_p[1]  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            if (r_s1_conj == CPX_CONJ) begin
                r_s2_p[0] <= SW'(r_s1_ii) + SW'(r_s1_qq);
                r_s2_p[1] <= SW'(r_s1_qi) - SW'(r_s1_iq);
            end else begin
                r_s2_p[0] <= SW'(r_s1_ii) - SW'(r_s1_qq);
                r_s2_p[1] <= SW'(r_s1_iq) + SW'(r_s1_qi);
            end
        end
    end

    logic signed [acc_bits-1:0] r_acc [2];
    logic                       r_acc_sat;
    logic                       r_first;
    logic                       r_s3_done;

    logic signed [acc_bits:0]   w_sum      [2];
    logic signed [acc_bits-1:0] w_acc_next [2];
    logic                       w_acc_sat  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
        // One guard bit above the accumulator exposes signed overflow as a sign mismatch.
        assign w_sum[gi]      = (acc_bits+1)'(r_acc[gi]) + (acc_bits+1)'(r_s2_p[gi]);
        assign w_acc_sat[gi]  = ~r_first & (w_sum[gi][acc_bits] ^ w_sum[gi][acc_bits-1]);
        assign w_acc_next[gi] = r_first        ? acc_bits'(r_s2_p[gi]) :
                                w_acc_sat[gi]  ? (w_sum[gi][acc_bits] ? ACC_MIN : ACC_MAX) :
                                                 w_sum[gi][acc_bits-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc[0]  <= '0;
            r_acc[1]  <= '0;
            r_acc_sat <= 1'b0;
            r_first   <= 1'b1;
            r_s3_done <= 1'b0;
        end else begin
            r_s3_done <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                r_acc[0]  <= w_acc_next[0];
                r_acc[1]  <= w_acc_next[1];
                r_acc_sat <= (r_first ? 1'b0 : r_acc_sat) | w_acc_sat[0] | w_acc_sat[1];
                r_first   <= r_s2_last;
            end
        end
    end

    // Output stage reads the finished frame sum while S3 may already be loading the next frame.
    logic signed [out_bits-1:0] w_out     [2];
    logic                       w_out_sat [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        cpx_round_sat #(
            .acc_bits  (acc_bits),
            .out_bits  (out_bits),
            .out_shift (out_shift)
        ) u_round_sat (
            .i_acc (r_acc[gi]),
            .o_val (w_out[gi]),
            .o_sat (w_out_sat[gi])
        );
    end

    logic                       r_out_valid;
    logic signed [out_bits-1:0] r_out_i, r_out_q;
    logic                       r_out_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_out_valid <= r_s3_done;
            if (r_s3_done) begin
                r_out_i   <= w_out[0];
                r_out_q   <= w_out[1];
                r_out_ovf <= r_acc_sat | w_out_sat[0] | w_out_sat[1];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_i     = r_out_i;
    assign bus.out_q     = r_out_q;
    assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_cpx_mac.sv
// Directed bench for cpx_mac: three instances (default, out_shift=4, acc_bits=26)
// share one stimulus stream; each test checks the instance it targets.
module tb_cpx_mac;

    logic clk;
    logic rst;
    logic in_valid, in_last, conj_y;
    logic signed [11:0] xi, xq, yi, yq;

    int n_cmp;
    int n_bad;

    cpx_mac_if #(.x_bits(12), .y_bits(12), .out_bits(24)) bus_a ();
    cpx_mac_if #(.x_bits(12), .y_bits(12), .out_bits(24)) bus_r ();
    cpx_mac_if #(.x_bits(12), .y_bits(12), .out_bits(26)) bus_s ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_last  = in_last;
    assign bus_a.conj_y   = conj_y;
    assign bus_a.xi       = xi;
    assign bus_a.xq       = xq;
    assign bus_a.yi       = yi;
    assign bus_a.yq       = yq;
    assign bus_r.in_valid = in_valid;
    assign bus_r.in_last  = in_last;
    assign bus_r.conj_y   = conj_y;
    assign bus_r.xi       = xi;
    assign bus_r.xq       = xq;
    assign bus_r.yi       = yi;
    assign bus_r.yq       = yq;
    assign bus_s.in_valid = in_valid;
    assign bus_s.in_last  = in_last;
    assign bus_s.conj_y   = conj_y;
    assign bus_s.xi       = xi;
    assign bus_s.xq       = xq;
    assign bus_s.yi       = yi;
    assign bus_s.yq       = yq;

    cpx_mac #(.x_bits(12), .y_bits(12), .acc_bits(40), .out_bits(24), .out_shift(0))
        u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    cpx_mac #(.x_bits(12), .y_bits(12), .acc_bits(40), .out_bits(24), .out_shift(4))
        u_dut_r (.clk(clk), .rst(rst), .bus(bus_r));
    cpx_mac #(.x_bits(12), .y_bits(12), .acc_bits(26), .out_bits(26), .out_shift(0))
        u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic v, input logic l, input logic c,
                        input int a_i, input int a_q, input int b_i, input int b_q);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        conj_y   = c;
        xi = 12'(a_i);
        xq = 12'(a_q);
        yi = 12'(b_i);
        yq = 12'(b_q);
    endtask

    // Idles the inputs for ncyc cycles and records the pulses seen on one instance.
    task automatic collect(input int sel, input int ncyc, output int cyc, output int cnt,
                           output logic signed [39:0] oi, output logic signed [39:0] oq,
                           output logic ovf);
        cyc = 0;
        cnt = 0;
        oi  = '0;
        oq  = '0;
        ovf = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (sel == 0 && bus_a.out_valid) begin
                cnt++; cyc = c; oi = bus_a.out_i; oq = bus_a.out_q; ovf = bus_a.out_ovf;
            end else if (sel == 1 && bus_r.out_valid) begin
                cnt++; cyc = c; oi = bus_r.out_i; oq = bus_r.out_q; ovf = bus_r.out_ovf;
            end else if (sel == 2 && bus_s.out_valid) begin
                cnt++; cyc = c; oi = bus_s.out_i; oq = bus_s.out_q; ovf = bus_s.out_ovf;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; conj_y = 1'b0;
        xi = 12'sd100; xq = 12'sd100; yi = 12'sd100; yq = 12'sd100;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus_a.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus_a.out_valid); end
        n_cmp++; if (bus_a.out_i !== 24'sd0) begin n_bad++; $display("FAIL reset_out_i got %0d want 0", bus_a.out_i); end
        n_cmp++; if (bus_a.out_q !== 24'sd0) begin n_bad++; $display("FAIL reset_out_q got %0d want 0", bus_a.out_q); end
        n_cmp++; if (bus_a.out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", bus_a.out_ovf); end
        rst = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (bus_a.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_no_pulse got %0b want 0", bus_a.out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_multiply();
        int cyc, cnt; logic signed [39:0] oi, oq; logic ovf;
        send(1'b1, 1'b1, 1'b0, 3, 4, 5, -2);
        collect(0, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL mul_pulses got %0d want 1", cnt); end
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL mul_latency got %0d want 4", cyc); end
        n_cmp++; if (oi !== 40'sd23) begin n_bad++; $display("FAIL mul_out_i got %0d want 23", oi); end
        n_cmp++; if (oq !== 40'sd14) begin n_bad++; $display("FAIL mul_out_q got %0d want 14", oq); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL mul_ovf got %0b want 0", ovf); end
        $display("test_multiply out=(%0d,%0d) ovf=%0b at +%0d", oi, oq, ovf, cyc);
    endtask

    task automatic test_conj();
        int cyc, cnt; logic signed [39:0] oi, oq; logic ovf;
        send(1'b1, 1'b1, 1'b1, 3, 4, 5, -2);
        collect(0, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL conj_pulses got %0d want 1", cnt); end
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL conj_latency got %0d want 4", cyc); end
        n_cmp++; if (oi !== 40'sd7) begin n_bad++; $display("FAIL conj_out_i got %0d want 7", oi); end
        n_cmp++; if (oq !== 40'sd26) begin n_bad++; $display("FAIL conj_out_q got %0d want 26", oq); end
        n_cmp++; if (bus_a.out_i !== 24'sd7) begin n_bad++; $display("FAIL conj_hold got %0d want 7", bus_a.out_i); end
        $display("test_conj out=(%0d,%0d) ovf=%0b at +%0d", oi, oq, ovf, cyc);
    endtask

    task automatic test_out_sat_gaps();
        int cyc, cnt; logic signed [39:0] oi, oq; logic ovf;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, (i == 3), 1'b0, -2048, 0, -2048, 0);
            if (i < 3) begin
                send(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
                send(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
            end
        end
        collect(0, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL osat_pulses got %0d want 1", cnt); end
        n_cmp++; if (oi !== 40'sd8388607) begin n_bad++; $display("FAIL osat_out_i got %0d want 8388607", oi); end
        n_cmp++; if (oq !== 40'sd0) begin n_bad++; $display("FAIL osat_out_q got %0d want 0", oq); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL osat_ovf got %0b want 1", ovf); end
        $display("test_out_sat_gaps out=(%0d,%0d) ovf=%0b", oi, oq, ovf);
    endtask

    task automatic test_rounding();
        int cyc, cnt; logic signed [39:0] oi, oq; logic ovf;
        send(1'b1, 1'b0, 1'b0, 3, 1, 4, 0);
        send(1'b1, 1'b1, 1'b0, 3, 1, 4, 0);
        collect(1, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL rnd_pos_pulses got %0d want 1", cnt); end
        n_cmp++; if (oi !== 40'sd2) begin n_bad++; $display("FAIL rnd_pos_out_i got %0d want 2", oi); end
        n_cmp++; if (oq !== 40'sd1) begin n_bad++; $display("FAIL rnd_pos_out_q got %0d want 1", oq); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rnd_pos_ovf got %0b want 0", ovf); end
        $display("test_rounding (24,8) -> (%0d,%0d)", oi, oq);
        send(1'b1, 1'b0, 1'b0, -3, -1, 4, 0);
        send(1'b1, 1'b1, 1'b0, -3, -1, 4, 0);
        collect(1, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (oi !== -40'sd1) begin n_bad++; $display("FAIL rnd_neg_out_i got %0d want -1", oi); end
        n_cmp++; if (oq !== 40'sd0) begin n_bad++; $display("FAIL rnd_neg_out_q got %0d want 0", oq); end
        $display("test_rounding (-24,-8) -> (%0d,%0d)", oi, oq);
    endtask

    task automatic test_acc_sat();
        int cyc, cnt; logic signed [39:0] oi, oq; logic ovf;
        // Eight products of 2^22 reach 2^25, one past the 26-bit accumulator limit.
        for (int i = 0; i < 8; i++) send(1'b1, (i == 7), 1'b0, -2048, 0, -2048, 0);
        collect(2, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL asat_pulses got %0d want 1", cnt); end
        n_cmp++; if (oi !== 40'sd33554431) begin n_bad++; $display("FAIL asat_out_i got %0d want 33554431", oi); end
        n_cmp++; if (oq !== 40'sd0) begin n_bad++; $display("FAIL asat_out_q got %0d want 0", oq); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL asat_ovf got %0b want 1", ovf); end
        $display("test_acc_sat out=(%0d,%0d) ovf=%0b", oi, oq, ovf);
        send(1'b1, 1'b1, 1'b0, 1, 0, 1, 0);
        collect(2, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (oi !== 40'sd1) begin n_bad++; $display("FAIL asat_next_out_i got %0d want 1", oi); end
        n_cmp++; if (oq !== 40'sd0) begin n_bad++; $display("FAIL asat_next_out_q got %0d want 0", oq); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL asat_next_ovf got %0b want 0", ovf); end
        $display("test_acc_sat next out=(%0d,%0d) ovf=%0b", oi, oq, ovf);
    endtask

    task automatic test_reset_midframe();
        int cyc, cnt; logic signed [39:0] oi, oq; logic ovf;
        send(1'b1, 1'b0, 1'b0, 1, 0, 1, 0);
        send(1'b1, 1'b0, 1'b0, 1, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; xi = 12'sd100; xq = 12'sd0; yi = 12'sd1; yq = 12'sd0;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_last = 1'b1; xi = 12'sd1; xq = 12'sd0; yi = 12'sd1; yq = 12'sd0;
        collect(0, 8, cyc, cnt, oi, oq, ovf);
        n_cmp++; if (cnt !== 1) begin n_bad++; $display("FAIL rstmid_pulses got %0d want 1", cnt); end
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rstmid_latency got %0d want 4", cyc); end
        n_cmp++; if (oi !== 40'sd1) begin n_bad++; $display("FAIL rstmid_out_i got %0d want 1", oi); end
        n_cmp++; if (oq !== 40'sd0) begin n_bad++; $display("FAIL rstmid_out_q got %0d want 0", oq); end
        $display("test_reset_midframe out=(%0d,%0d) pulses=%0d", oi, oq, cnt);
    endtask

    task automatic test_back_to_back();
        int xs [6] = '{1, 3, 5, 7, -9, -11};
        int qs [6] = '{2, 4, -6, 8, 10, -12};
        int ei [3] = '{4, 12, -20};
        int eq [3] = '{6, 2, -2};
        logic exp_v;
        int f;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            exp_v = (k == 5 || k == 7 || k == 9);
            n_cmp++;
            if (bus_a.out_valid !== exp_v) begin
                n_bad++; $display("FAIL b2b_valid k=%0d got %0b want %0b", k, bus_a.out_valid, exp_v);
            end
            if (exp_v) begin
                f = (k - 5) / 2;
                n_cmp++;
                if (bus_a.out_i !== 24'(ei[f])) begin n_bad++; $display("FAIL b2b_out_i f=%0d got %0d want %0d", f, bus_a.out_i, ei[f]); end
                n_cmp++;
                if (bus_a.out_q !== 24'(eq[f])) begin n_bad++; $display("FAIL b2b_out_q f=%0d got %0d want %0d", f, bus_a.out_q, eq[f]); end
                $display("test_back_to_back frame %0d out=(%0d,%0d)", f, bus_a.out_i, bus_a.out_q);
            end
            if (k < 6) begin
                in_valid = 1'b1; in_last = (k % 2 == 1); conj_y = 1'b0;
                xi = 12'(xs[k]); xq = 12'(qs[k]); yi = 12'sd1; yq = 12'sd0;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_multiply();
        test_conj();
        test_out_sat_gaps();
        test_rounding();
        test_acc_sat();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
